// File: rtl/decode_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_unit_if
// Description : Fetch-to-decode and decode-to-execute bundle for decode_unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_unit_if;
    logic [31:0] i_instr;
    logic        i_valid;
    logic [31:0] i_NPC;
    logic        i_flush;
    logic [31:0] i_rs1_data;
    logic [31:0] i_rs2_data;
    logic [4:0]  o_rs1;
    logic [4:0]  o_rs2;
    logic        o_stall;
    logic [2:0]  o_ALUop;
    logic [2:0]  o_func3;
    logic        o_func7;
    logic [31:0] o_Imm_SignExt;
    logic [31:0] o_NPC;
    logic [31:0] o_A;
    logic [31:0] o_B;
    logic [4:0]  o_write_reg;
    logic        o_RegWrite;
    logic        o_MemToReg;
    logic        o_MemRead;
    logic        o_MemWrite;
    logic        o_illegal;

    modport slave (
        input  i_instr, i_valid, i_NPC, i_flush, i_rs1_data, i_rs2_data,
        output o_rs1, o_rs2, o_stall, o_ALUop, o_func3, o_func7, o_Imm_SignExt,
               o_NPC, o_A, o_B, o_write_reg, o_RegWrite, o_MemToReg,
               o_MemRead, o_MemWrite, o_illegal
    );

    modport master (
        output i_instr, i_valid, i_NPC, i_flush, i_rs1_data, i_rs2_data,
        input  o_rs1, o_rs2, o_stall, o_ALUop, o_func3, o_func7, o_Imm_SignExt,
               o_NPC, o_A, o_B, o_write_reg, o_RegWrite, o_MemToReg,
               o_MemRead, o_MemWrite, o_illegal
    );
endinterface
`default_nettype wire

// File: rtl/decode_unit.sv
`default_nettype none
// ============================================================================
// Module      : decode_unit
// Description : RV32 decode stage with ID/EX register, load-use stall, flush.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_unit (
    input  wire logic    i_clk,
    input  wire logic    i_reset,
    decode_unit_if.slave bus
);
    localparam logic [6:0] c_OP_LOAD   = 7'h03;
    localparam logic [6:0] c_OP_STORE  = 7'h23;
    localparam logic [6:0] c_OP_BRANCH = 7'h63;
    localparam logic [6:0] c_OP_REG    = 7'h33;
    localparam logic [6:0] c_OP_IMM    = 7'h13;
    localparam logic [6:0] c_OP_LUI    = 7'h37;
    localparam logic [6:0] c_OP_AUIPC  = 7'h17;
    localparam logic [6:0] c_OP_JAL    = 7'h6F;
    localparam logic [6:0] c_OP_JALR   = 7'h67;

    localparam logic [2:0] c_ALU_LDST  = 3'd0;
    localparam logic [2:0] c_ALU_BR    = 3'd1;
    localparam logic [2:0] c_ALU_REG   = 3'd2;
    localparam logic [2:0] c_ALU_IMM   = 3'd3;
    localparam logic [2:0] c_ALU_LUI   = 3'd4;
    localparam logic [2:0] c_ALU_AUIPC = 3'd5;
    localparam logic [2:0] c_ALU_JAL   = 3'd6;
    localparam logic [2:0] c_ALU_JALR  = 3'd7;

    logic [31:0] w_instr;
    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [2:0]  w_f3;

    assign w_instr  = bus.i_instr;
    assign w_opcode = w_instr[6:0];
    assign w_rd     = w_instr[11:7];
    assign w_rs1    = w_instr[19:15];
    assign w_rs2    = w_instr[24:20];
    assign w_f3     = w_instr[14:12];

    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_b_scaled;
    logic [31:0] w_imm_j_scaled;
    logic [31:0] w_imm_u_scaled;

    assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
    assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
    assign w_imm_u = {w_instr[31:12], 12'b0};
    // Offsets dropped by two bits; the ALU shifts them back when adding to NPC
    assign w_imm_b_scaled = {{21{w_instr[31]}}, w_instr[31], w_instr[7],
                             w_instr[30:25], w_instr[11:9]};
    assign w_imm_j_scaled = {{13{w_instr[31]}}, w_instr[31], w_instr[19:12],
                             w_instr[20], w_instr[30:22]};
    assign w_imm_u_scaled = {{2{w_instr[31]}}, w_instr[31:12], 10'b0};

    logic [2:0]  w_aluop;
    logic [2:0]  w_func3;
    logic        w_func7;
    logic [31:0] w_imm;
    logic        w_regwrite;
    logic        w_memtoreg;
    logic        w_memread;
    logic        w_memwrite;
    logic        w_legal;
    logic        w_rs1_used;
    logic        w_rs2_used;

    always_comb begin
        w_aluop    = c_ALU_LDST;
        w_func3    = w_f3;
        w_func7    = 1'b0;
        w_imm      = '0;
        w_regwrite = 1'b0;
        w_memtoreg = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_legal    = 1'b1;
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b0;
        case (w_opcode)
            c_OP_LOAD: begin
                w_aluop    = c_ALU_LDST;
                w_imm      = w_imm_i;
                w_memread  = 1'b1;
                w_memtoreg = 1'b1;
                w_regwrite = 1'b1;
            end
            c_OP_STORE: begin
                w_aluop    = c_ALU_LDST;
                w_imm      = w_imm_s;
                w_memwrite = 1'b1;
                w_rs2_used = 1'b1;
            end
            c_OP_BRANCH: begin
                w_aluop    = c_ALU_BR;
                w_imm      = w_imm_b_scaled;
                w_rs2_used = 1'b1;
            end
            c_OP_REG: begin
                w_aluop    = c_ALU_REG;
                w_func7    = w_instr[30];
                w_regwrite = 1'b1;
                w_rs2_used = 1'b1;
            end
            c_OP_IMM: begin
                w_aluop    = c_ALU_IMM;
                w_regwrite = 1'b1;
                w_func7    = (w_f3 == 3'd5) ? w_instr[30] : 1'b0;
                w_imm      = (w_f3 == 3'd1 || w_f3 == 3'd5) ? {27'b0, w_instr[24:20]}
                                                            : w_imm_i;
            end
            c_OP_LUI: begin
                w_aluop    = c_ALU_LUI;
                w_func3    = 3'd0;
                w_imm      = w_imm_u;
                w_regwrite = 1'b1;
                w_rs1_used = 1'b0;
            end
            c_OP_AUIPC: begin
                w_aluop    = c_ALU_AUIPC;
                w_func3    = 3'd0;
                w_imm      = w_imm_u_scaled;
                w_regwrite = 1'b1;
                w_rs1_used = 1'b0;
            end
            c_OP_JAL: begin
                w_aluop    = c_ALU_JAL;
                w_func3    = 3'd0;
                w_imm      = w_imm_j_scaled;
                w_regwrite = 1'b1;
                w_rs1_used = 1'b0;
            end
            c_OP_JALR: begin
                w_aluop    = c_ALU_JALR;
                w_imm      = w_imm_i;
                w_regwrite = 1'b1;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
        if (w_rd == 5'd0) begin
            w_regwrite = 1'b0;
        end
    end

    logic [2:0]  r_aluop;
    logic [2:0]  r_func3;
    logic        r_func7;
    logic [31:0] r_imm;
    logic [31:0] r_npc;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [4:0]  r_write_reg;
    logic        r_regwrite;
    logic        r_memtoreg;
    logic        r_memread;
    logic        r_memwrite;
    logic        r_illegal;

    logic w_hazard;
    logic w_issue;
    logic w_flag_illegal;

    assign w_hazard = r_memread && (r_write_reg != 5'd0) &&
                      ((w_rs1_used && (w_rs1 == r_write_reg)) ||
                       (w_rs2_used && (w_rs2 == r_write_reg)));
    assign w_issue        = bus.i_valid && !bus.i_flush && !w_hazard && w_legal;
    assign w_flag_illegal = bus.i_valid && !bus.i_flush && !w_hazard && !w_legal;

    always_ff @(posedge i_clk) begin
        if (i_reset || !w_issue) begin
            r_aluop     <= c_ALU_IMM;
            r_func3     <= 3'd0;
            r_func7     <= 1'b0;
            r_imm       <= '0;
            r_npc       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_write_reg <= 5'd0;
            r_regwrite  <= 1'b0;
            r_memtoreg  <= 1'b0;
            r_memread   <= 1'b0;
            r_memwrite  <= 1'b0;
        end else begin
            r_aluop     <= w_aluop;
            r_func3     <= w_func3;
            r_func7     <= w_func7;
            r_imm       <= w_imm;
            r_npc       <= bus.i_NPC;
            r_a         <= bus.i_rs1_data;
            r_b         <= bus.i_rs2_data;
            r_write_reg <= w_regwrite ? w_rd : 5'd0;
            r_regwrite  <= w_regwrite;
            r_memtoreg  <= w_memtoreg;
            r_memread   <= w_memread;
            r_memwrite  <= w_memwrite;
        end
        r_illegal <= w_flag_illegal && !i_reset;
    end

    assign bus.o_rs1         = w_rs1;
    assign bus.o_rs2         = w_rs2;
    assign bus.o_stall       = bus.i_valid && w_hazard && !bus.i_flush && !i_reset;
    assign bus.o_ALUop       = r_aluop;
    assign bus.o_func3       = r_func3;
    assign bus.o_func7       = r_func7;
    assign bus.o_Imm_SignExt = r_imm;
    assign bus.o_NPC         = r_npc;
    assign bus.o_A           = r_a;
    assign bus.o_B           = r_b;
    assign bus.o_write_reg   = r_write_reg;
    assign bus.o_RegWrite    = r_regwrite;
    assign bus.o_MemToReg    = r_memtoreg;
    assign bus.o_MemRead     = r_memread;
    assign bus.o_MemWrite    = r_memwrite;
    assign bus.o_illegal     = r_illegal;
endmodule
`default_nettype wire
